// File: rtl/s27_pkg.sv
// Shared types and s27 next-state/output functions.
// Used by the channel core, the array top and the bench model.
package s27_pkg;

    localparam int S27_STATE_BITS = 3;
    localparam logic [15:0] S27_MISR_POLY = 16'h100B;

    typedef struct packed {
        logic g5;
        logic g6;
        logic g7;
    } s27_state_t;

    function automatic logic s27_g17(
        input s27_state_t s,
        input logic g0,
        input logic g1,
        input logic g3
    );
        logic n5;
        logic n6;
        n5 = (g0 | ~s.g6) & (g1 | s.g7);
        n6 = ~((s.g6 & ~g0) | g3);
        return n6 | n5 | s.g5;
    endfunction

    function automatic s27_state_t s27_next(
        input s27_state_t s,
        input logic g0,
        input logic g1,
        input logic g2,
        input logic g17
    );
        s27_state_t n;
        n.g5 = g17 & g0;
        n.g6 = ~g17;
        n.g7 = ~g2 & (g1 | s.g7);
        return n;
    endfunction

endpackage

// File: rtl/s27_core.sv
// One s27 channel: three state flops with reset/scan/capture/hold priority.
// Scan path runs scan_in -> g5 -> g6 -> g7 -> scan_out.
module s27_core
    import s27_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic g0,
    input  logic g1,
    input  logic g2,
    input  logic g3,
    input  logic cap_en,
    input  logic se,
    input  logic scan_in,
    output logic scan_out,
    output logic g17
);

    s27_state_t st;

    assign g17      = s27_g17(st, g0, g1, g3);
    assign scan_out = st.g7;

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
        end else if (se) begin
            st <= '{g5: scan_in, g6: st.g5, g7: st.g6};
        end else if (cap_en) begin
            st <= s27_next(st, g0, g1, g2, g17);
        end
    end

endmodule

// File: rtl/s27_scan_array.sv
// N s27 channels on one full-scan chain, with optional MISR over G17.
// Define S27_MISR_EN to build the signature register; otherwise MISR_SIG is 0.
module s27_scan_array
    import s27_pkg::*;
#(
    parameter int                N         = 2,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(S27_MISR_POLY)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [N-1:0]      G0,
    input  logic [N-1:0]      G1,
    input  logic [N-1:0]      G2,
    input  logic [N-1:0]      G3,
    input  logic              CAP_EN,
    input  logic              SE,
    input  logic              SI,
    output logic              SO,
    output logic [N-1:0]      G17,
    input  logic              MISR_CLR,
    output logic [MISR_W-1:0] MISR_SIG
);

    logic [N:0] chain;

    assign chain[0] = SI;
    assign SO       = chain[N];

    for (genvar c = 0; c < N; c++) begin : g_ch
        s27_core u_core (
            .clk      (CK),
            .rst      (RST),
            .g0       (G0[c]),
            .g1       (G1[c]),
            .g2       (G2[c]),
            .g3       (G3[c]),
            .cap_en   (CAP_EN),
            .se       (SE),
            .scan_in  (chain[c]),
            .scan_out (chain[c+1]),
            .g17      (G17[c])
        );
    end

`ifdef S27_MISR_EN
    logic [MISR_W-1:0] fold;
    logic [MISR_W-1:0] sig;

    always_comb begin
        fold = '0;
        for (int c = 0; c < N; c++) begin
            fold[c % MISR_W] = fold[c % MISR_W] ^ G17[c];
        end
    end

    // Clear wins over update; scan edges leave the signature alone.
    always_ff @(posedge CK) begin
        if (RST || MISR_CLR) begin
            sig <= '0;
        end else if (CAP_EN && !SE) begin
            sig <= {sig[MISR_W-2:0], 1'b0}
                 ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                 ^ fold;
        end
    end

    assign MISR_SIG = sig;
`else
    logic unused_misr_clr;

    assign unused_misr_clr = MISR_CLR;
    assign MISR_SIG        = '0;
`endif

endmodule

// File: tb/tb_s27_scan_array.sv
// Directed bench for s27_scan_array (N=2): reset, functional, scan, hold, MISR.
// Expected values are hand-derived from the s27 equations.
module tb_s27_scan_array;

    logic        CK = 1'b0;
    logic        RST;
    logic [1:0]  G0, G1, G2, G3;
    logic        CAP_EN, SE, SI, MISR_CLR;
    logic        SO;
    logic [1:0]  G17;
    logic [15:0] MISR_SIG;

    int n_chk  = 0;
    int n_fail = 0;

    s27_scan_array #(.N(2), .MISR_W(16), .MISR_POLY(16'h100B)) dut (
        .CK       (CK),
        .RST      (RST),
        .G0       (G0),
        .G1       (G1),
        .G2       (G2),
        .G3       (G3),
        .CAP_EN   (CAP_EN),
        .SE       (SE),
        .SI       (SI),
        .SO       (SO),
        .G17      (G17),
        .MISR_CLR (MISR_CLR),
        .MISR_SIG (MISR_SIG)
    );

    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] st0();
        return dut.g_ch[0].u_core.st;
    endfunction

    function automatic logic [2:0] st1();
        return dut.g_ch[1].u_core.st;
    endfunction

    logic [5:0] pat;

    initial begin
        RST = 1'b1; G0 = '0; G1 = '0; G2 = '0; G3 = '0;
        CAP_EN = 1'b1; SE = 1'b0; SI = 1'b0; MISR_CLR = 1'b0;
        step(); step();
        chk("rst_st0", 16'(st0()), 16'h0);
        chk("rst_st1", 16'(st1()), 16'h0);
        chk("rst_so", 16'(SO), 16'h0);
        chk("rst_g17", 16'(G17), 16'h3);
        chk("rst_misr", MISR_SIG, 16'h0);

        // Test 1: all inputs low, capture: state stays 000, G17=1.
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_g17", 16'(G17), 16'h3);
        end
        chk("t1_st0", 16'(st0()), 16'h0);
        chk("t1_st1", 16'(st1()), 16'h0);

        // Test 2: G3 forces G17 low, G6 lock, G0 releases.
        G3 = 2'b01; #1;
        chk("t2_g17_g3", 16'(G17), 16'h2);
        step();
        chk("t2_st_g6", 16'(st0()), 16'h2);
        G3 = 2'b00; #1;
        chk("t2_g17_lock", 16'(G17), 16'h2);
        step();
        chk("t2_g17_lock2", 16'(G17), 16'h2);
        chk("t2_st_lock", 16'(st0()), 16'h2);
        G0 = 2'b01; #1;
        chk("t2_g17_rel", 16'(G17), 16'h3);
        step();
        chk("t2_st_g5", 16'(st0()), 16'h4);

        // Test 3: G7 latch.
        G0 = '0; RST = 1'b1; step(); RST = 1'b0;
        G1 = 2'b01; G2 = 2'b00; step();
        chk("t3_set", 16'(st0()), 16'h1);
        G1 = 2'b00; step();
        chk("t3_hold", 16'(st0()), 16'h1);
        G2 = 2'b01; step();
        chk("t3_clr", 16'(st0()), 16'h0);
        G2 = '0;

        // Test 4: shift 101101, SO after edges 6..11; CAP_EN toggles.
        RST = 1'b1; step(); RST = 1'b0;
        pat = 6'b101101;
        SE = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            SI = (e <= 6) ? pat[6-e] : 1'b0;
            CAP_EN = e[0];
            step();
            if (e >= 6) chk("t4_so", 16'(SO), 16'(pat[11-e]));
            else        chk("t4_so_pre", 16'(SO), 16'h0);
        end

        // Test 5: load 110100 then hold with random inputs.
        RST = 1'b1; step(); RST = 1'b0;
        pat = 6'b110100;
        for (int e = 1; e <= 6; e++) begin
            SI = pat[6-e];
            step();
        end
        SE = 1'b0; CAP_EN = 1'b0; SI = 1'b0;
        for (int i = 0; i < 20; i++) begin
            G0 = 2'($urandom); G1 = 2'($urandom);
            G2 = 2'($urandom); G3 = 2'($urandom);
            SI = 1'($urandom);
            step();
        end
        chk("t5_st0", 16'(st0()), 16'h1);
        chk("t5_st1", 16'(st1()), 16'h3);
        chk("t5_so", 16'(SO), 16'h1);
        chk("t5_misr", MISR_SIG, 16'h0);
        SE = 1'b1; SI = 1'b1; step(); step();
        RST = 1'b1; step(); RST = 1'b0; SE = 1'b0;
        chk("t5_rst_st0", 16'(st0()), 16'h0);
        chk("t5_rst_st1", 16'(st1()), 16'h0);
        chk("t5_rst_so", 16'(SO), 16'h0);

        // Test 6: three captures with G17=11, then clear.
        G0 = '0; G1 = '0; G2 = '0; G3 = '0; SI = 1'b0;
        RST = 1'b1; step(); RST = 1'b0;
        CAP_EN = 1'b1;
`ifdef S27_MISR_EN
        step(); chk("t6_sig1", MISR_SIG, 16'h0003);
        step(); chk("t6_sig2", MISR_SIG, 16'h0005);
        step(); chk("t6_sig3", MISR_SIG, 16'h0009);
        MISR_CLR = 1'b1; step(); MISR_CLR = 1'b0;
        chk("t6_clr", MISR_SIG, 16'h0);
`else
        step(); step(); step();
        chk("t6_tied", MISR_SIG, 16'h0);
`endif
        chk("t6_g17", 16'(G17), 16'h3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
